// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake direction controller.
package snake_pkg;

    localparam int unsigned DIR_W    = 2;
    localparam int unsigned NUM_KEYS = 4;

    typedef enum logic [DIR_W-1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DEAD   = 2'd3
    } ctrl_state_t;

    // Flipping bit 1 of the encoding gives the 180-degree reverse.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/snake_dir_if.sv
// Player-side bundle: raw keys and game levels in, move strobes, direction and tick out.
//   master : game/player side (drives keys, pause, dead)
//   slave  : snake_dir_ctrl (drives strobes, dir, tick)
interface snake_dir_if;
    import snake_pkg::*;

    logic key_left;
    logic key_right;
    logic key_up;
    logic key_down;
    logic pause;
    logic dead;
    logic left;
    logic right;
    logic up;
    logic down;
    dir_t dir;
    logic tick;

    modport master (
        output key_left, key_right, key_up, key_down, pause, dead,
        input  left, right, up, down, dir, tick
    );

    modport slave (
        input  key_left, key_right, key_up, key_down, pause, dead,
        output left, right, up, down, dir, tick
    );

endinterface

// File: rtl/key_sync_edge.sv
// Key front end: 2-FF synchroniser followed by a registered rising-edge detector.
//   clk, reset (async, active-low)
//   din   : raw asynchronous key
//   pulse : one-cycle press pulse, third cycle after din is first sampled high
module key_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            meta  <= din;
            sync  <= meta;
            prev  <= sync;
            pulse <= sync & ~prev;
        end
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Converts player keys into paced one-cycle move strobes for the snake head.
//   clk, reset (async, active-low)
//   bus.key_*        : raw keys (asynchronous)
//   bus.pause/dead   : synchronous levels from game logic
//   bus.left/right/up/down : one-cycle move strobes, one cycle after tick
//   bus.dir          : current direction
//   bus.tick         : one-cycle pulse when the move counter wraps
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 8,
    parameter dir_t        START_DIR = DIR_RIGHT
) (
    input  logic        clk,
    input  logic        reset,
    snake_dir_if.slave  bus
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_RUN    = 2'(RUN);
    localparam logic [1:0] S_PAUSED = 2'(PAUSED);
    localparam logic [1:0] S_DEAD   = 2'(DEAD);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    dir_t                dir_q;
    dir_t                q0, q1;
    logic [1:0]          q_cnt;
    logic                tick_q;
    logic [NUM_KEYS-1:0] strobe_q;

    logic [NUM_KEYS-1:0] press;
    logic                press_valid;
    dir_t                press_dir;
    dir_t                ref_dir;
    logic                turn_ok;
    logic                active;
    logic                cnt_en;
    logic                tick_c;
    logic                push;
    logic                pop;
    logic                first_press;

    // Key front ends, indexed by direction encoding
    key_sync_edge u_key_up    (.clk(clk), .reset(reset), .din(bus.key_up),    .pulse(press[DIR_UP]));
    key_sync_edge u_key_right (.clk(clk), .reset(reset), .din(bus.key_right), .pulse(press[DIR_RIGHT]));
    key_sync_edge u_key_down  (.clk(clk), .reset(reset), .din(bus.key_down),  .pulse(press[DIR_DOWN]));
    key_sync_edge u_key_left  (.clk(clk), .reset(reset), .din(bus.key_left),  .pulse(press[DIR_LEFT]));

    // Press decode: only a lone pulse counts; ref is the last direction already committed
    always_comb begin
        press_valid = 1'b1;
        press_dir   = DIR_UP;
        unique case (press)
            4'b0001: press_dir = DIR_UP;
            4'b0010: press_dir = DIR_RIGHT;
            4'b0100: press_dir = DIR_DOWN;
            4'b1000: press_dir = DIR_LEFT;
            default: press_valid = 1'b0;
        endcase

        ref_dir = dir_q;
        if (q_cnt == 2'd2) begin
            ref_dir = q1;
        end else if (q_cnt == 2'd1) begin
            ref_dir = q0;
        end

        turn_ok     = press_valid && (press_dir != ref_dir) && (press_dir != opposite(ref_dir));
        active      = (state_q == S_RUN) || (state_q == S_PAUSED);
        cnt_en      = active && !bus.pause && !bus.dead;
        tick_c      = cnt_en && (cnt_q == CNT_MAX);
        push        = active && turn_ok && !bus.dead;
        pop         = tick_c && (q_cnt != 2'd0);
        first_press = (state_q == S_IDLE) && press_valid && !bus.dead;
    end

    // Next-state logic; dead overrides everything
    always_comb begin
        state_d = state_q;
        if (bus.dead) begin
            state_d = S_DEAD;
        end else begin
            case (state_q)
                S_IDLE:   if (press_valid) state_d = S_RUN;
                S_RUN:    if (bus.pause)   state_d = S_PAUSED;
                S_PAUSED: if (!bus.pause)  state_d = S_RUN;
                default:  state_d = S_DEAD;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Tick counter and direction; paused/dead simply stop the count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            dir_q <= START_DIR;
        end else begin
            if (first_press) begin
                cnt_q <= '0;
                dir_q <= press_dir;
            end else begin
                if (cnt_en) begin
                    cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
                end
                if (pop) begin
                    dir_q <= q0;
                end
            end
        end
    end

    // Two-entry turn queue, q0 is the head; push into a full queue needs a same-cycle pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q0    <= DIR_UP;
            q1    <= DIR_UP;
            q_cnt <= 2'd0;
        end else if (bus.dead) begin
            q_cnt <= 2'd0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (q_cnt == 2'd2) begin
                        q0 <= q1;
                        q1 <= press_dir;
                    end else begin
                        q0 <= press_dir;
                    end
                end
                2'b10: begin
                    if (q_cnt == 2'd0) begin
                        q0    <= press_dir;
                        q_cnt <= 2'd1;
                    end else if (q_cnt == 2'd1) begin
                        q1    <= press_dir;
                        q_cnt <= 2'd2;
                    end
                end
                2'b01: begin
                    q0    <= q1;
                    q_cnt <= q_cnt - 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Output registers: tick follows the wrap, strobe follows tick using the updated dir
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q   <= 1'b0;
            strobe_q <= '0;
        end else begin
            tick_q <= tick_c;
            if (tick_q && !bus.dead && (state_q != S_DEAD)) begin
                strobe_q <= NUM_KEYS'(4'b0001 << dir_q);
            end else begin
                strobe_q <= '0;
            end
        end
    end

    assign bus.up    = strobe_q[DIR_UP];
    assign bus.right = strobe_q[DIR_RIGHT];
    assign bus.down  = strobe_q[DIR_DOWN];
    assign bus.left  = strobe_q[DIR_LEFT];
    assign bus.dir   = dir_q;
    assign bus.tick  = tick_q;

endmodule
